// File: rtl/branch_predict_tracker.sv
// branch_predict_tracker: in-order FIFO of fetch predictions; registered BHT update and mispredict flush on resolve (optional BPT_STATS_EN counters)
module branch_predict_tracker #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int IDX_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_valid,
  input  logic [PC_W-1:0]            fetch_pc,
  input  logic                       fetch_pred_taken,
  input  logic [PC_W-1:0]            fetch_pred_target,
  output logic                       fetch_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  input  logic [PC_W-1:0]            res_target,
  output logic                       flush,
  output logic [PC_W-1:0]            flush_pc,
  output logic                       bht_en,
  output logic [IDX_W-1:0]           bht_write_addr,
  output logic                       bht_was_taken,
`ifdef BPT_STATS_EN
  output logic [15:0]                stat_branches,
  output logic [15:0]                stat_mispredicts,
`endif
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [PC_W-1:0] pc_q  [DEPTH];
  logic [PC_W-1:0] tgt_q [DEPTH];
  logic            pt_q  [DEPTH];
  logic [AW-1:0]   head, tail;
  logic            push, pop, mis;
  logic [PC_W-1:0] head_pc;
  assign head_pc     = pc_q[head];
  assign fetch_ready = !rst && occupancy < FULL && !flush;
  assign push        = fetch_valid && fetch_ready;
  assign pop         = res_valid && occupancy != '0;
  assign mis         = pop && ((res_taken != pt_q[head]) || (res_taken && pt_q[head] && res_target != tgt_q[head]));
  always_ff @(posedge clk) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      occupancy      <= '0;
      flush          <= 1'b0;
      flush_pc       <= '0;
      bht_en         <= 1'b0;
      bht_write_addr <= '0;
      bht_was_taken  <= 1'b0;
    end else begin
      bht_en         <= pop;
      bht_write_addr <= pop ? head_pc[IDX_W+1:2] : '0;
      bht_was_taken  <= pop && res_taken;
      flush          <= mis;
      flush_pc       <= mis ? (res_taken ? res_target : head_pc + PC_W'(4)) : '0;
      if (mis) begin
        head      <= '0;
        tail      <= '0;
        occupancy <= '0;
      end else begin
        if (push) begin
          pc_q[tail]  <= fetch_pc;
          pt_q[tail]  <= fetch_pred_taken;
          tgt_q[tail] <= fetch_pred_target;
          tail        <= tail + AW'(1);
        end
        if (pop) head <= head + AW'(1);
        occupancy <= occupancy + CW'(push) - CW'(pop);
      end
    end
  end
`ifdef BPT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (pop && stat_branches != 16'hFFFF) stat_branches <= stat_branches + 16'd1;
      if (mis && stat_mispredicts != 16'hFFFF) stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
`endif
endmodule
